// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
//   Control stage of the dds voice core. It takes the byte stream from
//   spi_slave (Avalon-ST source) and decodes framed commands into per-voice
//   frequency, envelope and wave-select registers. These registers drive the
//   phase accumulators and wave muxes continuously.
//
//   Frame: OPCODE, VOICE, payload (MSB first)
//     0x01 FREQ  payload hi, lo
//     0x02 ENV   payload 1 byte
//     0x03 WAVE  payload 1 byte, low WAVE_W bits used
//
//   Optional feature macro: SPI_CMD_CHECKSUM_EN
//     When it is defined, each frame ends with one trailing byte. That byte
//     is the XOR of all earlier bytes of the frame. A frame whose checksum
//     does not match is dropped and err_stb pulses.
//
// Ports
//   clk, nreset      clock, synchronous active-low reset
//   st_valid/st_data byte stream in; st_ready is low only in COMMIT
//   freq_bus         voice v at [v*FREQ_W +: FREQ_W]
//   env_bus          voice v at [v*ENV_W  +: ENV_W]
//   wave_bus         voice v at [v*WAVE_W +: WAVE_W]
//   update_stb       1-cycle pulse on each committed register write
//   last_cmd         opcode of the last committed frame
//   err_stb          1-cycle pulse on bad opcode, bad voice, timeout or
//                    checksum fail
// ---------------------------------------------------------------------------
module spi_cmd_decoder #(
    parameter int NUM_VOICES     = 8,
    parameter int FREQ_W         = 16,
    parameter int ENV_W          = 8,
    parameter int WAVE_W         = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         st_valid,
    input  logic [7:0]                   st_data,
    output logic                         st_ready,
    output logic [NUM_VOICES*FREQ_W-1:0] freq_bus,
    output logic [NUM_VOICES*ENV_W-1:0]  env_bus,
    output logic [NUM_VOICES*WAVE_W-1:0] wave_bus,
    output logic                         update_stb,
    output logic [7:0]                   last_cmd,
    output logic                         err_stb
);

    localparam logic [7:0] OP_FREQ = 8'h01;
    localparam logic [7:0] OP_ENV  = 8'h02;
    localparam logic [7:0] OP_WAVE = 8'h03;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      NV_LIM   = 9'(NUM_VOICES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VOICE,
        S_PAYLOAD,
`ifdef SPI_CMD_CHECKSUM_EN
        S_CHECK,
`endif
        S_COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [7:0]                   op_q;
    logic [7:0]                   voice_q;
    logic [15:0]                  data_q;
    logic                         pay_hi_done;
    logic [CNT_W-1:0]             tmo_cnt;
    logic [NUM_VOICES*FREQ_W-1:0] freq_q;
    logic [NUM_VOICES*ENV_W-1:0]  env_q;
    logic [NUM_VOICES*WAVE_W-1:0] wave_q;
    logic                         upd_q;
    logic                         err_q;
    logic [7:0]                   last_q;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]                   chk_q;
    logic                         chk_bad_q;
`endif

    logic accept;
    logic in_frame;
    logic tmo_hit;
    logic op_known;
    logic last_byte;
    logic voice_ok;

    assign op_known  = (st_data == OP_FREQ) || (st_data == OP_ENV) || (st_data == OP_WAVE);
    assign last_byte = (op_q != OP_FREQ) || pay_hi_done;
    assign voice_ok  = ({1'b0, voice_q} < NV_LIM);

    always_comb begin
        state_nxt = state;
        st_ready  = (state != S_COMMIT);
        accept    = st_valid && st_ready;
        in_frame  = (state != S_IDLE) && (state != S_COMMIT);
        // An accepted byte on the expiry edge takes priority over the timeout.
        tmo_hit   = in_frame && !accept && (tmo_cnt == TMO_LAST);

        case (state)
            S_IDLE:    if (accept && op_known) state_nxt = S_VOICE;
            S_VOICE:   if (accept) state_nxt = S_PAYLOAD;
            S_PAYLOAD: begin
                if (accept && last_byte) begin
`ifdef SPI_CMD_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_COMMIT;
`endif
                end
            end
`ifdef SPI_CMD_CHECKSUM_EN
            S_CHECK:   if (accept) state_nxt = S_COMMIT;
`endif
            S_COMMIT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        if (tmo_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= S_IDLE;
            op_q        <= '0;
            voice_q     <= '0;
            data_q      <= '0;
            pay_hi_done <= 1'b0;
            tmo_cnt     <= '0;
            freq_q      <= '0;
            env_q       <= '0;
            wave_q      <= '0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
            chk_q       <= '0;
            chk_bad_q   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            upd_q <= 1'b0;
            err_q <= 1'b0;

            if (!in_frame || accept || tmo_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) err_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_known) begin
                            op_q        <= st_data;
                            pay_hi_done <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
                            chk_q       <= st_data;
                            chk_bad_q   <= 1'b0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_VOICE: begin
                    if (accept) begin
                        voice_q <= st_data;
`ifdef SPI_CMD_CHECKSUM_EN
                        chk_q   <= chk_q ^ st_data;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        // Shifting MSB-first leaves a FREQ word in data_q[15:0].
                        // A 1-byte payload ends up in data_q[7:0].
                        data_q      <= {data_q[7:0], st_data};
                        pay_hi_done <= 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
                        chk_q       <= chk_q ^ st_data;
`endif
                    end
                end
`ifdef SPI_CMD_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) chk_bad_q <= (st_data != chk_q);
                end
`endif
                S_COMMIT: begin
`ifdef SPI_CMD_CHECKSUM_EN
                    if (!voice_ok || chk_bad_q) begin
`else
                    if (!voice_ok) begin
`endif
                        err_q <= 1'b1;
                    end else begin
                        upd_q  <= 1'b1;
                        last_q <= op_q;
                        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                            if (voice_q == v[7:0]) begin
                                case (op_q)
                                    OP_FREQ: freq_q[v*FREQ_W +: FREQ_W] <= data_q[FREQ_W-1:0];
                                    OP_ENV:  env_q[v*ENV_W +: ENV_W]    <= data_q[ENV_W-1:0];
                                    OP_WAVE: wave_q[v*WAVE_W +: WAVE_W] <= data_q[WAVE_W-1:0];
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign freq_bus   = freq_q;
    assign env_bus    = env_q;
    assign wave_bus   = wave_q;
    assign update_stb = upd_q;
    assign err_stb    = err_q;
    assign last_cmd   = last_q;

endmodule
